// File: rtl/cpu_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN,
    ST_SQUASH
  } squash_state_e;

  // Resolves beq/bne from the ALU zero flag; the reserved encoding never branches.
  function automatic logic br_cond(input logic [1:0] br, input logic zero);
    return ((br == BR_EQ) && zero) || ((br == BR_NE) && !zero);
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM pipeline register.
interface ex_mem_stage_if;
  import cpu_pkg::*;

  logic              ex_valid;
  logic [WORD_W-1:0] alu_r;
  logic              alu_zero;
  logic              alu_signal;
  logic              alu_not_move;
  logic              ex_rf_w;
  logic [4:0]        ex_rd;
  logic              ex_mem_w;
  logic              ex_mem_r;
  logic              ex_cmov;
  logic [1:0]        ex_br;
  logic              ex_slt;
  logic [WORD_W-1:0] ex_br_target;
  logic [WORD_W-1:0] ex_pc4;
  logic [WORD_W-1:0] ex_st_data;
  logic              mem_stall;

  logic              mem_valid;
  logic [WORD_W-1:0] mem_result;
  logic              mem_rf_w;
  logic [4:0]        mem_rd;
  logic              mem_mem_w;
  logic              mem_mem_r;
  logic [WORD_W-1:0] mem_st_data;
  logic [WORD_W-1:0] mem_pc4;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              squashing;

  // The pipeline stage itself.
  modport slave (
    input  ex_valid, alu_r, alu_zero, alu_signal, alu_not_move, ex_rf_w, ex_rd,
           ex_mem_w, ex_mem_r, ex_cmov, ex_br, ex_slt, ex_br_target, ex_pc4,
           ex_st_data, mem_stall,
    output mem_valid, mem_result, mem_rf_w, mem_rd, mem_mem_w, mem_mem_r,
           mem_st_data, mem_pc4, redirect, redirect_pc, squashing
  );

  // The surrounding pipeline (EX driver, MEM consumer, fetch).
  modport master (
    output ex_valid, alu_r, alu_zero, alu_signal, alu_not_move, ex_rf_w, ex_rd,
           ex_mem_w, ex_mem_r, ex_cmov, ex_br, ex_slt, ex_br_target, ex_pc4,
           ex_st_data, mem_stall,
    input  mem_valid, mem_result, mem_rf_w, mem_rd, mem_mem_w, mem_mem_r,
           mem_st_data, mem_pc4, redirect, redirect_pc, squashing
  );

endinterface

// File: rtl/branch_squash_fsm.sv
// Tracks wrong-path squashing after a taken branch and produces the fetch redirect pulse.
module branch_squash_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned SQUASH_N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic taken_i,
  input  logic accept_i,
  output logic kill_o,
  output logic redirect_o,
  output logic squashing_o
);

  squash_state_e state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    // A stalled edge holds everything, so a pending redirect survives the stall.
    if (accept_i) begin
      pend_d = taken_i;
      unique case (state_q)
        ST_RUN: begin
          if (taken_i) begin
            state_d = ST_SQUASH;
            cnt_d   = SQUASH_N[1:0];
          end
        end
        ST_SQUASH: begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  assign kill_o      = (state_q == ST_SQUASH);
  assign squashing_o = (state_q == ST_SQUASH);
  assign redirect_o  = pend_q & accept_i;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with cmov write gating, slt result select and branch redirect.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       SQUASH_N = 2,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);

  logic              accept;
  logic              fsm_kill;
  logic              killed;
  logic              taken;
  logic              redirect;
  logic              squashing;

  logic              valid_q;
  logic [WORD_W-1:0] result_q;
  logic [WORD_W-1:0] result_d;
  logic              rf_w_q;
  logic              rf_w_d;
  logic [4:0]        rd_q;
  logic              mem_w_q;
  logic              mem_r_q;
  logic [WORD_W-1:0] st_data_q;
  logic [WORD_W-1:0] pc4_q;
  logic [WORD_W-1:0] redirect_pc_q;

  assign accept = ~bus.mem_stall;
  assign killed = fsm_kill | ~bus.ex_valid;
  assign taken  = ~killed & br_cond(bus.ex_br, bus.alu_zero);

  assign result_d = bus.ex_slt ? {{(WORD_W-1){1'b0}}, bus.alu_signal} : bus.alu_r;
  assign rf_w_d   = bus.ex_rf_w & ~(bus.ex_cmov & bus.alu_not_move);

  branch_squash_fsm #(
    .SQUASH_N (SQUASH_N)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .taken_i     (taken),
    .accept_i    (accept),
    .kill_o      (fsm_kill),
    .redirect_o  (redirect),
    .squashing_o (squashing)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      result_q      <= '0;
      rf_w_q        <= 1'b0;
      rd_q          <= 5'd0;
      mem_w_q       <= 1'b0;
      mem_r_q       <= 1'b0;
      st_data_q     <= '0;
      pc4_q         <= RESET_PC;
      redirect_pc_q <= '0;
    end else if (accept) begin
      // A taken branch travels on as a valid bubble: no side effects downstream.
      valid_q   <= ~killed;
      rf_w_q    <= ~killed & ~taken & rf_w_d;
      mem_w_q   <= ~killed & ~taken & bus.ex_mem_w;
      mem_r_q   <= ~killed & ~taken & bus.ex_mem_r;
      result_q  <= result_d;
      rd_q      <= bus.ex_rd;
      st_data_q <= bus.ex_st_data;
      pc4_q     <= bus.ex_pc4;
      if (taken) begin
        redirect_pc_q <= bus.ex_br_target;
      end
    end
  end

  assign bus.mem_valid   = valid_q;
  assign bus.mem_result  = result_q;
  assign bus.mem_rf_w    = rf_w_q;
  assign bus.mem_rd      = rd_q;
  assign bus.mem_mem_w   = mem_w_q;
  assign bus.mem_mem_r   = mem_r_q;
  assign bus.mem_st_data = st_data_q;
  assign bus.mem_pc4     = pc4_q;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.squashing   = squashing;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and random checks of ex_mem_stage against a behavioural reference model.
module tb_ex_mem_stage;

  localparam int unsigned SQ  = 2;
  localparam logic [31:0] RPC = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if bus ();

  ex_mem_stage #(
    .SQUASH_N (SQ),
    .RESET_PC (RPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state.
  logic        m_valid, m_rf_w, m_mem_w, m_mem_r, m_pend;
  logic [4:0]  m_rd;
  logic [31:0] m_result, m_st, m_pc4, m_rpc;
  int          m_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit killed, taken;
    if (rst) begin
      {m_valid, m_rf_w, m_mem_w, m_mem_r, m_pend} = '0;
      m_rd = '0; m_result = '0; m_st = '0; m_rpc = '0;
      m_pc4  = RPC;
      m_left = 0;
    end else if (!bus.mem_stall) begin
      killed = (m_left > 0) || !bus.ex_valid;
      taken  = !killed && ((bus.ex_br == 2'b01 && bus.alu_zero) ||
                           (bus.ex_br == 2'b10 && !bus.alu_zero));
      m_valid  = !killed;
      m_rf_w   = !killed && !taken && bus.ex_rf_w && !(bus.ex_cmov && bus.alu_not_move);
      m_mem_w  = !killed && !taken && bus.ex_mem_w;
      m_mem_r  = !killed && !taken && bus.ex_mem_r;
      m_result = bus.ex_slt ? 32'(bus.alu_signal) : bus.alu_r;
      m_rd     = bus.ex_rd;
      m_st     = bus.ex_st_data;
      m_pc4    = bus.ex_pc4;
      m_pend   = taken;
      if (taken) m_rpc = bus.ex_br_target;
      if (m_left > 0) m_left--;
      if (taken) m_left = SQ;
    end
  endtask

  task automatic check_outputs();
    chk("valid",       32'(bus.mem_valid),  32'(m_valid));
    chk("result",      bus.mem_result,      m_result);
    chk("rf_w",        32'(bus.mem_rf_w),   32'(m_rf_w));
    chk("rd",          32'(bus.mem_rd),     32'(m_rd));
    chk("mem_w",       32'(bus.mem_mem_w),  32'(m_mem_w));
    chk("mem_r",       32'(bus.mem_mem_r),  32'(m_mem_r));
    chk("st_data",     bus.mem_st_data,     m_st);
    chk("pc4",         bus.mem_pc4,         m_pc4);
    chk("redirect",    32'(bus.redirect),   32'(m_pend && !bus.mem_stall));
    chk("redirect_pc", bus.redirect_pc,     m_rpc);
    chk("squashing",   32'(bus.squashing),  32'(m_left > 0));
  endtask

  // Inputs are already driven; check, take one edge, update model, move off the edge.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_nop();
    bus.ex_valid = 1'b0; bus.alu_r = '0; bus.alu_zero = 1'b0; bus.alu_signal = 1'b0;
    bus.alu_not_move = 1'b0; bus.ex_rf_w = 1'b0; bus.ex_rd = '0; bus.ex_mem_w = 1'b0;
    bus.ex_mem_r = 1'b0; bus.ex_cmov = 1'b0; bus.ex_br = 2'b00; bus.ex_slt = 1'b0;
    bus.ex_br_target = '0; bus.ex_pc4 = '0; bus.ex_st_data = '0; bus.mem_stall = 1'b0;
  endtask

  task automatic set_add(input logic [31:0] r, input logic [4:0] rd);
    set_nop();
    bus.ex_valid = 1'b1; bus.alu_r = r; bus.alu_zero = (r == 0);
    bus.ex_rf_w = 1'b1; bus.ex_rd = rd; bus.ex_pc4 = 32'h100;
  endtask

  task automatic set_store(input logic [31:0] d);
    set_nop();
    bus.ex_valid = 1'b1; bus.alu_r = 32'h200; bus.ex_mem_w = 1'b1; bus.ex_st_data = d;
  endtask

  task automatic set_beq(input logic [31:0] tgt);
    set_nop();
    bus.ex_valid = 1'b1; bus.ex_br = 2'b01; bus.alu_zero = 1'b1; bus.ex_br_target = tgt;
  endtask

  initial begin
    set_nop();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
    chk("reset_pc4", bus.mem_pc4, RPC);
    chk("reset_valid", 32'(bus.mem_valid), 32'd0);

    // Plain add.
    set_add(32'h5, 5'd3);
    cycle();
    chk("add_result", bus.mem_result, 32'h5);
    chk("add_rf_w", 32'(bus.mem_rf_w), 32'd1);
    chk("add_rd", 32'(bus.mem_rd), 32'd3);

    // movn fail then movz pass.
    set_add(32'h7, 5'd4); bus.ex_cmov = 1'b1; bus.alu_not_move = 1'b1;
    cycle();
    chk("cmov_fail_rf_w", 32'(bus.mem_rf_w), 32'd0);
    chk("cmov_fail_valid", 32'(bus.mem_valid), 32'd1);
    bus.alu_not_move = 1'b0;
    cycle();
    chk("cmov_pass_rf_w", 32'(bus.mem_rf_w), 32'd1);

    // slt.
    set_add(32'hFFFF_FFFE, 5'd5); bus.ex_slt = 1'b1; bus.alu_signal = 1'b1;
    cycle();
    chk("slt_result", bus.mem_result, 32'h1);

    // beq taken, two stores squashed, third instruction passes.
    set_beq(32'h40);
    cycle();
    set_store(32'hAAAA_0001);
    #1;
    chk("beq_redirect", 32'(bus.redirect), 32'd1);
    chk("beq_rpc", bus.redirect_pc, 32'h40);
    chk("beq_valid", 32'(bus.mem_valid), 32'd1);
    chk("beq_mem_w", 32'(bus.mem_mem_w), 32'd0);
    cycle();
    chk("sq1_redirect", 32'(bus.redirect), 32'd0);
    chk("sq1_valid", 32'(bus.mem_valid), 32'd0);
    chk("sq1_mem_w", 32'(bus.mem_mem_w), 32'd0);
    set_store(32'hAAAA_0002);
    cycle();
    chk("sq2_valid", 32'(bus.mem_valid), 32'd0);
    chk("sq2_mem_w", 32'(bus.mem_mem_w), 32'd0);
    chk("sq2_done", 32'(bus.squashing), 32'd0);
    set_store(32'hAAAA_0003);
    cycle();
    chk("post_valid", 32'(bus.mem_valid), 32'd1);
    chk("post_mem_w", 32'(bus.mem_mem_w), 32'd1);

    // bne not taken.
    set_nop(); bus.ex_valid = 1'b1; bus.ex_br = 2'b10; bus.alu_zero = 1'b1;
    cycle();
    chk("bne_redirect", 32'(bus.redirect), 32'd0);
    chk("bne_squashing", 32'(bus.squashing), 32'd0);

    // Taken branch, then three stalled cycles, then a single redirect pulse.
    set_beq(32'h80);
    cycle();
    set_add(32'h9, 5'd9); bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_rpc", bus.redirect_pc, 32'h80);
    bus.mem_stall = 1'b0;
    #1;
    chk("stall_release_redirect", 32'(bus.redirect), 32'd1);
    cycle();
    chk("stall_once", 32'(bus.redirect), 32'd0);

    // Reset in the middle of a squash.
    set_beq(32'hC0);
    cycle();
    set_store(32'h5555); rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_squashing", 32'(bus.squashing), 32'd0);
    chk("rst_rpc", bus.redirect_pc, 32'd0);
    chk("rst_pc4", bus.mem_pc4, RPC);
    cycle();

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      rst              = ($urandom_range(0, 49) == 0);
      bus.mem_stall    = ($urandom_range(0, 3) == 0);
      bus.ex_valid     = ($urandom_range(0, 4) != 0);
      bus.alu_r        = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      bus.alu_zero     = (bus.alu_r == 0);
      bus.alu_signal   = bus.alu_r[31];
      bus.alu_not_move = 1'($urandom_range(0, 1));
      bus.ex_rf_w      = 1'($urandom_range(0, 1));
      bus.ex_rd        = 5'($urandom);
      bus.ex_mem_w     = 1'($urandom_range(0, 1));
      bus.ex_mem_r     = 1'($urandom_range(0, 1));
      bus.ex_cmov      = 1'($urandom_range(0, 1));
      bus.ex_br        = 2'($urandom);
      bus.ex_slt       = 1'($urandom_range(0, 1));
      bus.ex_br_target = $urandom;
      bus.ex_pc4       = $urandom;
      bus.ex_st_data   = $urandom;
      cycle();
    end
    rst = 1'b0;
    set_nop();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the execute stage (ALU) and the memory stage.
- Captures the ALU result and flags (zero, sign, not_move) plus control from EX.
- Gates register-file write for conditional moves (movn/movz) and resolves beq/bne and slt.
- Raises a one-cycle redirect to fetch and squashes wrong-path instructions entering EX.

Parameters:
- SQUASH_N, 2: number of younger instructions squashed after a taken branch (1..3).
- RESET_PC, 32'h0000_0000: reset value of the mem_pc4 register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- ex_valid  in  1  EX holds a real instruction this cycle.
- alu_r  in  32  ALU result.
- alu_zero  in  1  ALU result == 0.
- alu_signal  in  1  ALU result bit 31.
- alu_not_move  in  1  ALU says the conditional move fails.
- ex_rf_w  in  1  instruction writes the register file.
- ex_rd  in  5  destination register.
- ex_mem_w  in  1  store.
- ex_mem_r  in  1  load.
- ex_cmov  in  1  instruction is movn/movz.
- ex_br  in  2  branch type: 00 none, 01 beq, 10 bne, 11 reserved (treated as none).
- ex_slt  in  1  result is the set-less-than bit.
- ex_br_target  in  32  branch target.
- ex_pc4  in  32  PC+4 of the instruction.
- ex_st_data  in  32  store data.
- mem_stall  in  1  downstream not ready; hold all registers.
- mem_valid  out  1  registered valid.
- mem_result  out  32  registered result.
- mem_rf_w  out  1  registered, gated write enable.
- mem_rd  out  5  registered destination register.
- mem_mem_w  out  1  registered store strobe.
- mem_mem_r  out  1  registered load strobe.
- mem_st_data  out  32  registered store data.
- mem_pc4  out  32  registered PC+4.
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  32  registered branch target.
- squashing  out  1  high while the FSM is in SQUASH.

Behaviour:
- Reset values (rst sampled high at a rising edge): every registered output is 0, except mem_pc4 = RESET_PC. FSM goes to RUN and the squash counter to 0. Reset overrides mem_stall.
- Latency: one cycle from EX inputs to mem_* outputs.
- Accept: an edge with mem_stall = 0 accepts the EX inputs. An edge with mem_stall = 1 holds every register and the FSM, and redirect is forced low.
- Kill: an instruction is killed when FSM = SQUASH or ex_valid = 0. A killed instruction loads mem_valid = 0, mem_rf_w = 0, mem_mem_w = 0 and mem_mem_r = 0; the data registers may still load.
- mem_result = {31'b0, alu_signal} when ex_slt = 1, otherwise alu_r.
- mem_rf_w = ex_rf_w & ~(ex_cmov & alu_not_move) for a non-killed instruction.
- Branch taken = non-killed & ((ex_br == 01 & alu_zero) | (ex_br == 10 & ~alu_zero)).
- On an accepting edge with branch taken:
  - redirect = 1 on the next cycle only.
  - redirect_pc = ex_br_target.
  - FSM goes to SQUASH with the counter set to SQUASH_N.
  - The branch itself is passed downstream with valid = 1 and all write strobes cleared.
- FSM states:
  - RUN: no squash in progress; EX instructions are not killed by the FSM.
  - SQUASH: each accepting edge kills the EX slot (even when ex_valid = 0) and decrements the counter. Counter reaching 0 returns the FSM to RUN on that same edge.
  - A branch arriving during SQUASH is itself killed and never redirects.
- Stall during SQUASH: the counter is not decremented.
- Stall in the cycle after a taken branch: the redirect pulse is emitted on the first non-stalled cycle, never more than once.
- Arithmetic: none beyond the gating above; all widths are exact and there is no sign extension.

Decomposition:
- Shared package cpu_pkg:
  - Branch-type constants BR_NONE, BR_EQ, BR_NE.
  - FSM state encoding ST_RUN, ST_SQUASH.
  - Constant WORD_W = 32.
- Sub-module branch_squash_fsm: contains the FSM, squash counter and redirect pulse. Inputs: taken, accept. Outputs: kill, redirect.
- The top level holds the datapath registers.

Test Plan:
- Plain add: alu_r = 32'h0000_0005, ex_rf_w = 1, ex_rd = 3, stall = 0 -> next cycle mem_result = 5, mem_rf_w = 1, mem_rd = 3, mem_valid = 1, redirect = 0.
- movn fail, then movz pass:
  - ex_cmov = 1, alu_not_move = 1, ex_rf_w = 1 -> mem_rf_w = 0, mem_valid = 1.
  - Repeat with alu_not_move = 0 -> mem_rf_w = 1.
- slt: ex_slt = 1, alu_r = 32'hFFFF_FFFE, alu_signal = 1 -> mem_result = 32'h0000_0001.
- beq taken with SQUASH_N = 2: ex_br = 01, alu_zero = 1, ex_br_target = 32'h0000_0040, followed by two valid stores ->
  - redirect = 1 for exactly one cycle with redirect_pc = 32'h40.
  - The two stores appear with mem_valid = 0 and mem_mem_w = 0.
  - The third instruction passes with mem_valid = 1.
- bne not taken: ex_br = 10, alu_zero = 1 -> redirect stays 0 and squashing stays 0.
- Stall and reset:
  - Hold mem_stall = 1 for 3 cycles after a taken branch -> outputs are frozen and redirect = 0 during the stall, then a single pulse once the stall releases.
  - Assert rst mid-SQUASH -> all outputs 0 and the FSM in RUN on the next cycle.
